cmp_entry_ctrl: RTL

//  Sequencer for the two-digit BCD min/max comparator display. Captures operand A, then

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/btn_pulse.sv | 41 ++++
 rtl/cmp_entry_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the BCD min/max entry sequencer.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'b00,
        ST_LOAD_B  = 2'b01,
        ST_SHOW    = 2'b10,
        ST_RECOVER = 2'b11
    } state_t;

    localparam logic [3:0]  BCD_MAX       = 4'd9;
    localparam int unsigned DB_CYCLES_DEF = 500000;
    localparam int unsigned DB_W_DEF      = 19;

    // Equal operands fall through to a, which is what the display expects.
    function automatic logic [3:0] pick_result(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       sel_min);
        if (sel_min)
            return (b < a) ? b : a;
        else
            return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Debounces one raw active-low push-button and emits a registered 1-cycle press pulse.
module btn_pulse
    import cmp_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned DB_W      = DB_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic pulse
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] cnt;
    logic            settle;

    assign settle = (btn_n != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b1;
            pulse <= 1'b0;
        end else begin
            // Only the released->pressed transition of the debounced level pulses.
            pulse <= settle && !btn_n;
            if (btn_n == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= btn_n;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_entry_ctrl.sv
// Entry sequencer: captures A then B from the switches, shows max/min, MODE toggles selection.
module cmp_entry_ctrl
    import cmp_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned DB_W      = DB_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       enter_n,
    input  logic       mode_n,
    output logic [3:0] disp_a,
    output logic [3:0] disp_b,
    output logic [3:0] disp_r,
    output logic       blank_a,
    output logic       blank_b,
    output logic       blank_r,
    output logic       sel_min,
    output logic       err,
    output logic [1:0] state
);

    logic enter_pulse;
    logic mode_pulse;
    logic enter_level;
    logic mode_level;
    logic unused_levels;

    btn_pulse #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_enter (
        .clk   (clk),
        .rst   (rst),
        .btn_n (enter_n),
        .level (enter_level),
        .pulse (enter_pulse)
    );

    btn_pulse #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_mode (
        .clk   (clk),
        .rst   (rst),
        .btn_n (mode_n),
        .level (mode_level),
        .pulse (mode_pulse)
    );

    // Debounced levels are only consumed by the board top.
    assign unused_levels = enter_level ^ mode_level;

    state_t     state_q, state_d;
    logic [3:0] a_d, b_d, r_d;
    logic       ba_d, bb_d, br_d, sel_d, err_d;
    logic       sw_valid;

    assign sw_valid = (sw <= BCD_MAX);
    assign state    = state_q;

    always_comb begin
        state_d = state_q;
        a_d     = disp_a;
        b_d     = disp_b;
        r_d     = disp_r;
        ba_d    = blank_a;
        bb_d    = blank_b;
        br_d    = blank_r;
        err_d   = err;
        // Mode is applied first so a same-edge entry into SHOW uses the new selection.
        sel_d   = sel_min ^ mode_pulse;

        case (state_q)
            ST_LOAD_A: begin
                if (enter_pulse) begin
                    if (sw_valid) begin
                        a_d     = sw;
                        ba_d    = 1'b0;
                        err_d   = 1'b0;
                        state_d = ST_LOAD_B;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_B: begin
                if (enter_pulse) begin
                    if (sw_valid) begin
                        b_d     = sw;
                        bb_d    = 1'b0;
                        br_d    = 1'b0;
                        r_d     = pick_result(disp_a, sw, sel_d);
                        err_d   = 1'b0;
                        state_d = ST_SHOW;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHOW: begin
                if (enter_pulse) begin
                    a_d     = '0;
                    b_d     = '0;
                    r_d     = '0;
                    ba_d    = 1'b1;
                    bb_d    = 1'b1;
                    br_d    = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_LOAD_A;
                end else begin
                    r_d = pick_result(disp_a, disp_b, sel_d);
                end
            end
            default: begin
                a_d     = '0;
                b_d     = '0;
                r_d     = '0;
                ba_d    = 1'b1;
                bb_d    = 1'b1;
                br_d    = 1'b1;
                err_d   = 1'b0;
                state_d = ST_LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD_A;
            disp_a  <= '0;
            disp_b  <= '0;
            disp_r  <= '0;
            blank_a <= 1'b1;
            blank_b <= 1'b1;
            blank_r <= 1'b1;
            sel_min <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_a  <= a_d;
            disp_b  <= b_d;
            disp_r  <= r_d;
            blank_a <= ba_d;
            blank_b <= bb_d;
            blank_r <= br_d;
            sel_min <= sel_d;
            err     <= err_d;
        end
    end

endmodule
